mem_responder: RTL
==================

# mem_responder

Memory responder that serves the core's instruction-fetch and data-memory ports from a single word-addressed array. It sits opposite the pipelined core: it answers `insn_addr` with `insn`, and answers `data_addr`/`data_w`/`data_out` with `data_in`. A boot-load front end fills the array from a streaming handshake before the core is released.

## Interface

Parameters:
- `AW`, default 10, address width in words; array holds 2^AW 32-bit words.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ld_valid`  in  1  load word available.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  marks the final load word; qualified by `ld_valid & ld_ready`.
- `ld_ready`  out  1  responder accepts a load word this cycle.
- `run`  out  1  load phase finished; core may fetch.
- `insn_addr`  in  32  fetch word address from the core.
- `insn`  out  32  fetched word.
- `data_w`  in  1  core store enable.
- `data_addr`  in  32  data word address.
- `data_out`  in  32  store data from the core.
- `data_in`  out  32  load data to the core.
- `fault`  out  1  sticky out-of-range flag.
- `fault_addr`  out  32  address of the first out-of-range access.

## Operation

- **FSM states:** LOAD and RUN.
- **Reset:** state=LOAD, `ld_ptr`=0, `ld_ready`=1, `run`=0, `insn`=0, `data_in`=0, `fault`=0, `fault_addr`=0. Array contents are not reset.
- **LOAD:**
  - On `ld_valid & ld_ready`: write `ld_data` to `mem[ld_ptr]`, then `ld_ptr`++.
  - If `ld_last` is set, or `ld_ptr`==2^AW-1, on that accepted beat, the state goes to RUN at the same edge.
  - `ld_valid` with `ld_ready`=0 is ignored.
  - Core stores are ignored. `insn` and `data_in` are forced to 0, which the core executes as a no-op.
- **RUN:**
  - `ld_ready`=0 and `run`=1. Loader inputs are ignored.
  - Fetch reads `mem[insn_addr]`.
  - Data read returns `mem[data_addr]` into `data_in`.
  - If `data_w`=1, `data_out` is written to `mem[data_addr]`.
- **In-range test:** an address is in range iff bits [31:AW] are all zero. The array index is `addr[AW-1:0]`.
- **Out-of-range access (RUN only):**
  - Reads return 0. Writes are dropped.
  - A fault is raised by an out-of-range fetch, or by a store with `data_w`=1. An out-of-range data read with `data_w`=0 raises no fault, because the ALU drives `data_addr` every cycle.
  - On the first such event, `fault`←1 and `fault_addr`← offending address.
  - If fetch and store both fault in the same cycle, the fetch address is captured.
  - Later faults do not update `fault_addr`. Only reset clears the flag.
- **Write-first forwarding:** if a store commits at an edge and the fetch or data read at that same edge targets the same word, the read returns the new `data_out`, not the old content.
- **Reset mid-operation:** asynchronously returns the block to LOAD with all outputs at reset values. Array contents are retained, so the loader may overwrite only a prefix.

## Timing

- Reads are synchronous with one-cycle latency. An address presented during cycle n gives valid `insn`/`data_in` after edge n+1, and the value is held until the next edge.
- Store commits at the edge where `data_w`=1. A read of that address presented in the following cycle sees the new value.
- Load handshake: a word transfers on each edge where `ld_valid & ld_ready`, giving a throughput of one word per cycle.
- LOAD→RUN:
  - `run` and the deassertion of `ld_ready` appear right after the edge that accepted the last beat.
  - The first fetch address is sampled at the next edge, so the first non-zero `insn` appears one cycle after `run` rises.
- `fault` and `fault_addr` update at the edge of the offending access. They are visible in the next cycle.

## Test plan

- **Load and run:**
  - Stimulus: with AW=4, stream 0x11,0x22,0x33 with `ld_last` on the third beat, then `insn_addr`=1.
  - Required: `ld_ready` falls and `run` rises after beat 3; `insn`=0x22 one cycle after the address is applied; `insn`=0 throughout LOAD.
- **Auto-end on full:**
  - Stimulus: with AW=2, stream 4 words without `ld_last`.
  - Required: RUN is entered after beat 4; a fifth `ld_valid` is ignored and `mem[0]` is unchanged.
- **Store and forwarding:**
  - Stimulus: in RUN, `data_w`=1, `data_addr`=5, `data_out`=0xDEADBEEF, with `insn_addr`=5 in the same cycle.
  - Required: `insn` and `data_in` both read 0xDEADBEEF after that edge.
- **Out-of-range:**
  - Stimulus: with AW=4, a store to 0x20, then a fetch from 0x40.
  - Required: `fault`=1 and `fault_addr`=0x20; `fault_addr` stays 0x20 after the fetch; `insn`=0; the store is dropped (a read of 0x0 shows the unchanged old value). A data read of 0x30 with `data_w`=0 raises no fault.
- **Reset mid-run:**
  - Stimulus: pulse `rst_n` low asynchronously between edges while in RUN.
  - Required: all outputs drop to reset values immediately and the state is LOAD. After reloading only word 0, a fetch of word 1 returns its previous content.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed memory serving the core's fetch and data ports, with a
// streaming boot-load front end that fills the array before releasing the core.
module mem_responder #(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        run,
    input  logic [31:0] insn_addr,
    output logic [31:0] insn,
    input  logic        data_w,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [31:0]   mem [2**AW];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ld_ptr_q, ld_ptr_d;
    logic [31:0]   insn_q, insn_d;
    logic [31:0]   data_in_q, data_in_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_addr_q, fault_addr_d;

    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;

    logic          insn_ok, data_ok, ld_fire, store;
    logic          fetch_fault, store_fault;
    logic [AW-1:0] insn_idx, data_idx;

    assign insn_ok  = (insn_addr[31:AW] == '0);
    assign data_ok  = (data_addr[31:AW] == '0);
    assign insn_idx = insn_addr[AW-1:0];
    assign data_idx = data_addr[AW-1:0];
    assign ld_fire  = (state_q == S_LOAD) && ld_valid;
    assign store    = (state_q == S_RUN) && data_w && data_ok;

    assign fetch_fault = (state_q == S_RUN) && !insn_ok;
    assign store_fault = (state_q == S_RUN) && data_w && !data_ok;

    always_comb begin
        state_d      = state_q;
        ld_ptr_d     = ld_ptr_q;
        insn_d       = 32'd0;
        data_in_d    = 32'd0;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        we           = 1'b0;
        wa           = ld_ptr_q;
        wd           = ld_data;

        if (state_q == S_LOAD) begin
            if (ld_fire) begin
                we       = 1'b1;
                ld_ptr_d = ld_ptr_q + 1'b1;
                if (ld_last || ld_ptr_q == '1)
                    state_d = S_RUN;
            end
        end else begin
            if (store) begin
                we = 1'b1;
                wa = data_idx;
                wd = data_out;
            end
            // Write-first: a read of the word being stored sees the new data.
            if (insn_ok)
                insn_d = (store && data_idx == insn_idx) ? data_out : mem[insn_idx];
            if (data_ok)
                data_in_d = store ? data_out : mem[data_idx];

            // Fetch takes priority when both ports fault together.
            if (!fault_q && (fetch_fault || store_fault)) begin
                fault_d      = 1'b1;
                fault_addr_d = fetch_fault ? insn_addr : data_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            ld_ptr_q     <= '0;
            insn_q       <= 32'd0;
            data_in_q    <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            ld_ptr_q     <= ld_ptr_d;
            insn_q       <= insn_d;
            data_in_q    <= data_in_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Array contents survive reset so a reload may overwrite only a prefix.
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    assign ld_ready   = (state_q == S_LOAD);
    assign run        = (state_q == S_RUN);
    assign insn       = insn_q;
    assign data_in    = data_in_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule
